// File: rtl/dport_arbiter_if.sv
// Request, memory-port and response signals of the demand/prefetch arbiter.
// The arbiter uses the slave view. Requesters and the memory controller use the master view.
interface dport_arbiter_if;
  logic        d_valid;
  logic [15:0] d_addr;
  logic        d_gnt;
  logic        p_valid;
  logic [15:0] p_addr;
  logic        p_gnt;
  logic        flush;
  logic        mem_re;
  logic [15:0] mem_raddr;
  logic        mem_ready;
  logic [15:0] mem_raddr_in;
  logic [15:0] mem_data;
  logic        d_ready;
  logic [15:0] d_raddr;
  logic [15:0] d_rdata;
  logic        p_ready;
  logic [15:0] p_raddr;
  logic [15:0] p_rdata;
  logic        busy;

  modport slave (
    input  d_valid, d_addr, p_valid, p_addr, flush,
           mem_ready, mem_raddr_in, mem_data,
    output d_gnt, p_gnt, mem_re, mem_raddr,
           d_ready, d_raddr, d_rdata, p_ready, p_raddr, p_rdata, busy
  );

  modport master (
    output d_valid, d_addr, p_valid, p_addr, flush,
           mem_ready, mem_raddr_in, mem_data,
    input  d_gnt, p_gnt, mem_re, mem_raddr,
           d_ready, d_raddr, d_rdata, p_ready, p_raddr, p_rdata, busy
  );
endinterface

// File: rtl/dport_arbiter.sv
// Demand/prefetch arbiter for one controller read port. Outstanding reads are tracked in
// issue order, so later requests to an in-flight address share that read's response.
//   state | meaning
//   RUN   | granting requests, responses routed
//   DRAIN | flush seen: no grants until flush drops and nothing is outstanding
module dport_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dport_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE + 1);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [15:0]       fifo_addr [DEPTH];
  logic [DEPTH-1:0]  fifo_od, fifo_op;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve;
  logic [DEPTH-1:0]  live, d_hit, p_hit;
  logic              pop, push, full, starve_full;
  logic              d_match, p_match, d_elig, p_elig, d_gnt, p_gnt;
  logic [15:0]       push_addr;
  int                off;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop         = bus.mem_ready && (count != '0);
  assign full        = (count == CW'(DEPTH));
  assign starve_full = (starve == SW'(STARVE));

  // The head entry being popped this cycle no longer counts as in flight.
  always_comb begin
    live  = '0;
    d_hit = '0;
    p_hit = '0;
    off   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = (i >= int'(rd_ptr)) ? i - int'(rd_ptr) : i + DEPTH - int'(rd_ptr);
      live[i]  = (off < int'(count)) && !(pop && (i == int'(rd_ptr)));
      d_hit[i] = live[i] && (fifo_addr[i] == bus.d_addr);
      p_hit[i] = live[i] && (fifo_addr[i] == bus.p_addr);
    end
  end

  assign d_match = |d_hit;
  assign p_match = |p_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.flush) state_nxt = DRAIN;
      DRAIN:   if (!bus.flush && (count == '0)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Grant is also withheld in the cycle flush first rises, before the state has moved.
  always_comb begin
    d_elig      = rst_n && (state == RUN) && !bus.flush && bus.d_valid && (d_match || !full);
    p_elig      = rst_n && (state == RUN) && !bus.flush && bus.p_valid && (p_match || !full);
    p_gnt       = p_elig && (!d_elig || starve_full);
    d_gnt       = d_elig && !p_gnt;
    bus.d_gnt   = d_gnt;
    bus.p_gnt   = p_gnt;
    bus.busy    = rst_n && ((state == DRAIN) || (count != '0));
    bus.d_ready = rst_n && pop && fifo_od[rd_ptr];
    bus.p_ready = rst_n && pop && fifo_op[rd_ptr];
    bus.d_raddr = bus.mem_raddr_in;
    bus.p_raddr = bus.mem_raddr_in;
    bus.d_rdata = bus.mem_data;
    bus.p_rdata = bus.mem_data;
  end

  assign push      = (d_gnt && !d_match) || (p_gnt && !p_match);
  assign push_addr = d_gnt ? bus.d_addr : bus.p_addr;

  always_ff @(posedge clk) begin
    if (push) fifo_addr[wr_ptr] <= push_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      starve        <= '0;
      fifo_od       <= '0;
      fifo_op       <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_raddr <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr == PW'(i))) begin
          fifo_od[i] <= d_gnt;
          fifo_op[i] <= p_gnt;
        end else if (d_gnt && d_hit[i]) begin
          fifo_od[i] <= 1'b1;
        end
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.mem_re <= push;
      if (push) bus.mem_raddr <= push_addr;
      if (p_gnt || !bus.p_valid)       starve <= '0;
      else if (d_gnt && !starve_full)  starve <= starve + 1'b1;
    end
  end
endmodule

// File: doc/dport_arbiter.md
DPORT_ARBITER -- requirements
Module: dport_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, max outstanding memory requests; SHALL be <= 5, the memory controller data queue depth.
REQ-002 Parameter STARVE, default 4, consecutive demand grants tolerated while prefetch waits.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 d_valid  in  1  demand load request; held until d_gnt.
REQ-006 d_addr  in  16  demand address.
REQ-007 d_gnt  out  1  combinational; demand request accepted this cycle.
REQ-008 p_valid  in  1  prefetch request; held until p_gnt.
REQ-009 p_addr  in  16  prefetch address.
REQ-010 p_gnt  out  1  combinational; prefetch request accepted this cycle.
REQ-011 flush  in  1  stop granting and drain outstanding requests.
REQ-012 mem_re  out  1  registered read-enable to controller data port.
REQ-013 mem_raddr  out  16  registered read address to controller.
REQ-014 mem_ready  in  1  controller response pulse, one cycle per request, in issue order.
REQ-015 mem_raddr_in  in  16  address of returning response.
REQ-016 mem_data  in  16  data of returning response.
REQ-017 d_ready / d_raddr / d_rdata  out  1/16/16  demand response pulse, address, data.
REQ-018 p_ready / p_raddr / p_rdata  out  1/16/16  prefetch fill pulse, address, data.
REQ-019 busy  out  1  high when state is DRAIN or outstanding count != 0.

Function
REQ-020 Tracking FIFO of DEPTH entries {addr[15:0], own_d, own_p}; count register 0..DEPTH.
REQ-021 States RUN, DRAIN; RUN->DRAIN when flush=1; DRAIN->RUN when flush=0 and count=0; no grants in DRAIN.
REQ-022 Grant eligibility in RUN: count < DEPTH (registered value); at most one grant per cycle.
REQ-023 Priority: demand over prefetch, except prefetch wins when starve counter = STARVE and both valid.
REQ-024 Starve counter: +1 on each d_gnt while p_valid=1 (saturates at STARVE); cleared on p_gnt or when p_valid=0.
REQ-025 Demand match: d_addr equals a valid entry not being popped this cycle -> d_gnt=1, no memory request, entry own_d set, count unchanged; eligible even when count=DEPTH.
REQ-026 Prefetch match: p_addr equals any valid entry not being popped -> p_gnt=1, request dropped, no state change; eligible even when count=DEPTH.
REQ-027 Unmatched grant: push {addr, own}, count+1; next cycle mem_re=1 for exactly one cycle with mem_raddr=addr (issue latency 1 cycle).
REQ-028 Unmatched demand and unmatched prefetch in same cycle: only winner of REQ-023 granted.
REQ-029 On mem_ready with count>0: pop head; same cycle d_ready=own_d, p_ready=own_p, both raddr outputs=mem_raddr_in, both rdata=mem_data; count-1.
REQ-030 Push and pop in same cycle: count unchanged; FIFO correct at count=DEPTH-1 and wrap-around of pointers.
REQ-031 mem_ready with count=0: ignored, no ready pulse.
REQ-032 mem_raddr_in != head addr on pop: busy stays valid, response still routed per head; bench flags as error.
REQ-033 Response outputs combinational from mem_ready/mem_*; d_ready/p_ready low in all other cycles.

Reset
REQ-034 rst_n=0 at posedge: state=RUN, count=0, FIFO pointers=0, starve=0, mem_re=0, mem_raddr=0.
REQ-035 During reset cycles d_gnt, p_gnt, d_ready, p_ready, busy SHALL be 0.
REQ-036 Reset mid-operation discards all outstanding entries; subsequent stale mem_ready pulses handled per REQ-031.

Verification
REQ-037 Reset, then d_valid, d_addr=0x0010 -> d_gnt same cycle; next cycle mem_re=1, mem_raddr=0x0010; mem_ready, mem_data=0xBEEF -> d_ready=1, d_rdata=0xBEEF, p_ready=0.
REQ-038 Prefetch 0x0040 outstanding, then demand 0x0040 -> d_gnt, no mem_re; one mem_ready -> d_ready and p_ready both 1 with same data.
REQ-039 Issue 4 unmatched requests without responses -> 5th unmatched d_valid sees d_gnt=0 until a mem_ready; matching p_addr still granted and dropped.
REQ-040 d_valid and p_valid held high with distinct new addresses -> grant order D,D,D,D,P,D... (STARVE=4).
REQ-041 flush with 2 outstanding -> no grants, busy=1 until both mem_ready pulses delivered, then RUN and busy=0.
REQ-042 rst_n low with 3 outstanding, release, then mem_ready -> no ready outputs, count=0.
